// File: rtl/product_accumulator.sv
// product_accumulator
//   Sums a programmed number of consecutive valid 16-bit products from the
//   multiplier stream into an AccWidth-bit accumulator. It presents the
//   result on a valid/ready port. The upstream stream is never stalled.
//   Products that arrive outside a job are discarded and flagged on drop_o.
//
// Optional feature macro: ACC_SATURATE_EN
//   defined   -> on carry out the accumulator saturates to all ones for the
//                rest of the job
//   undefined -> the accumulator wraps modulo 2^AccWidth
//   overflow_o is set on carry out in both builds.
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   prod_i       16-bit unsigned product
//   prod_valid_i prod_i valid this cycle
//   start_i      begin a job (IDLE, or DONE with acc_ready_i high)
//   len_i        number of products in the job, sampled with start_i
//   acc_o        accumulated result
//   acc_valid_o  acc_o valid
//   acc_ready_i  downstream accepts acc_o
//   overflow_o   carry out of AccWidth occurred during this job
//   drop_o       one-cycle pulse, a valid product was discarded
//   busy_o       state is not IDLE
module product_accumulator #(
    parameter int unsigned AccWidth   = 20,
    parameter int unsigned CountWidth = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [15:0]           prod_i,
    input  logic                  prod_valid_i,
    input  logic                  start_i,
    input  logic [CountWidth-1:0] len_i,
    output logic [AccWidth-1:0]   acc_o,
    output logic                  acc_valid_o,
    input  logic                  acc_ready_i,
    output logic                  overflow_o,
    output logic                  drop_o,
    output logic                  busy_o
);

    localparam int unsigned SumWidth = AccWidth + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                state_q;
    logic [CountWidth-1:0] remaining_q;

    logic [SumWidth-1:0]   sum_c;
    logic                  carry_c;
    logic [AccWidth-1:0]   acc_next_c;
    logic                  start_c;
    logic                  drop_c;

    // Adder with carry out, next accumulator value, and start/drop qualifiers
    always_comb begin
        sum_c      = SumWidth'(acc_o) + SumWidth'(prod_i);
        carry_c    = sum_c[AccWidth];
`ifdef ACC_SATURATE_EN
        acc_next_c = carry_c ? {AccWidth{1'b1}} : sum_c[AccWidth-1:0];
`else
        acc_next_c = sum_c[AccWidth-1:0];
`endif
        // A start is only honoured in IDLE, or in DONE when the result is taken
        start_c = start_i && ((state_q == IDLE) || ((state_q == DONE) && acc_ready_i));
        // A product seen outside ACC is lost unless that cycle starts a job
        drop_c  = prod_valid_i && (state_q != ACC) && !start_c;
    end

    // Control FSM with registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            acc_o       <= '0;
            acc_valid_o <= 1'b0;
            overflow_o  <= 1'b0;
            drop_o      <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            drop_o <= drop_c;
            case (state_q)
                IDLE, DONE: begin
                    if (start_c) begin
                        acc_o      <= '0;
                        overflow_o <= 1'b0;
                        busy_o     <= 1'b1;
                        if (len_i != '0) begin
                            remaining_q <= len_i;
                            acc_valid_o <= 1'b0;
                            state_q     <= ACC;
                        end else begin
                            // Empty job: a zero result is presented next cycle
                            remaining_q <= '0;
                            acc_valid_o <= 1'b1;
                            state_q     <= DONE;
                        end
                    end else if ((state_q == DONE) && acc_ready_i) begin
                        acc_valid_o <= 1'b0;
                        busy_o      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                ACC: begin
                    if (prod_valid_i) begin
                        acc_o       <= acc_next_c;
                        remaining_q <= remaining_q - CountWidth'(1);
                        if (carry_c) begin
                            overflow_o <= 1'b1;
                        end
                        if (remaining_q == CountWidth'(1)) begin
                            acc_valid_o <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    acc_valid_o <= 1'b0;
                    busy_o      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator
//   Directed bench for product_accumulator. Two instances share stimulus:
//   the default 20-bit build and a 16-bit build used for the overflow case.
//   Expected results come from a small reference model and are queued when
//   a job is started, then popped when the DUT presents its result.
module tb_product_accumulator;

`ifdef ACC_SATURATE_EN
    localparam bit Sat = 1'b1;
`else
    localparam bit Sat = 1'b0;
`endif

    typedef struct {
        longint unsigned acc;
        bit              ovf;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] prod;
    logic        prod_valid;
    logic        start;
    logic [3:0]  len;
    logic        acc_ready;

    logic [19:0] acc20;
    logic        valid20, ovf20, drop20, busy20;
    logic [15:0] acc16;
    logic        valid16, ovf16, drop16, busy16;

    exp_t q20[$];
    exp_t q16[$];

    int n_assert = 0;
    int n_fail   = 0;

    product_accumulator u_dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .prod_i      (prod),
        .prod_valid_i(prod_valid),
        .start_i     (start),
        .len_i       (len),
        .acc_o       (acc20),
        .acc_valid_o (valid20),
        .acc_ready_i (acc_ready),
        .overflow_o  (ovf20),
        .drop_o      (drop20),
        .busy_o      (busy20)
    );

    product_accumulator #(.AccWidth(16), .CountWidth(4)) u_dut16 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .prod_i      (prod),
        .prod_valid_i(prod_valid),
        .start_i     (start),
        .len_i       (len),
        .acc_o       (acc16),
        .acc_valid_o (valid16),
        .acc_ready_i (acc_ready),
        .overflow_o  (ovf16),
        .drop_o      (drop16),
        .busy_o      (busy16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(int unsigned w, bit sat, int unsigned p[$]);
        exp_t            e;
        longint unsigned max;
        max   = (64'd1 << w) - 64'd1;
        e.acc = 0;
        e.ovf = 1'b0;
        foreach (p[i]) begin
            e.acc = e.acc + longint'(p[i]);
            if (e.acc > max) begin
                e.ovf = 1'b1;
                e.acc = sat ? max : (e.acc & max);
            end
        end
        return e;
    endfunction

    task automatic chk(string tag, longint unsigned obs, longint unsigned exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply inputs, then advance to just after the next rising edge
    task automatic drive(bit s, int l, bit pv, int p, bit rdy);
        start      = s;
        len        = 4'(l);
        prod_valid = pv;
        prod       = 16'(p);
        acc_ready  = rdy;
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a presented result and compare against the queue
    task automatic check_result(string tag);
        exp_t e;
        int   waited = 0;
        while (!valid20 && waited < 4) begin
            drive(0, 0, 0, 0, 0);
            waited++;
        end
        chk({tag, "_valid"}, valid20, 1);
        if (q20.size() > 0) begin
            e = q20.pop_front();
            chk({tag, "_acc"}, acc20, e.acc);
            chk({tag, "_ovf"}, ovf20, e.ovf);
        end
        if (q16.size() > 0) begin
            e = q16.pop_front();
            chk({tag, "_acc16"}, acc16, e.acc);
            chk({tag, "_ovf16"}, ovf16, e.ovf);
        end
    endtask

    // Start a job (with an ignored product in the start cycle) and feed products
    task automatic run_job(int unsigned p[$]);
        q20.push_back(model(20, Sat, p));
        drive(1, p.size(), 1, 1000, 0);
        foreach (p[i]) drive(0, 0, 1, int'(p[i]), 0);
    endtask

    task automatic to_idle(string tag);
        drive(0, 0, 0, 0, 1);
        chk({tag, "_idle_busy"}, busy20, 0);
        chk({tag, "_idle_valid"}, valid20, 0);
    endtask

    initial begin
        int unsigned pq[$];

        rst_n = 1'b0;
        start = 1'b0; len = '0; prod_valid = 1'b0; prod = '0; acc_ready = 1'b0;
        #1;
        chk("rst_acc", acc20, 0);
        chk("rst_valid", valid20, 0);
        chk("rst_busy", busy20, 0);
        chk("rst_ovf", ovf20, 0);
        chk("rst_drop", drop20, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic job with explicit latency checks
        pq = '{12, 30, 56};
        q20.push_back(model(20, Sat, pq));
        drive(1, 3, 1, 1000, 0);
        chk("basic_busy", busy20, 1);
        chk("basic_start_drop", drop20, 0);
        drive(0, 0, 1, 12, 0);
        drive(0, 0, 1, 30, 0);
        chk("basic_early_valid", valid20, 0);
        drive(0, 0, 1, 56, 0);
        chk("basic_valid_edge", valid20, 1);
        check_result("basic");
        to_idle("basic");
        chk("basic_acc_hold", acc20, 98);

        // Drop in IDLE is a one-cycle pulse
        drive(0, 0, 1, 77, 0);
        chk("idle_drop", drop20, 1);
        drive(0, 0, 0, 0, 0);
        chk("idle_drop_clear", drop20, 0);

        // Gaps in the valid stream
        pq = '{65025, 65025};
        q20.push_back(model(20, Sat, pq));
        drive(1, 2, 0, 0, 0);
        drive(0, 0, 1, 65025, 0);
        drive(0, 0, 0, 11, 0);
        drive(0, 0, 0, 22, 0);
        chk("gap_early_valid", valid20, 0);
        drive(0, 0, 1, 65025, 0);
        chk("gap_valid_edge", valid20, 1);
        check_result("gap");
        to_idle("gap");

        // Back-pressure then a back-to-back job
        pq = '{12, 30, 56};
        run_job(pq);
        check_result("bp");
        for (int i = 0; i < 5; i++) begin
            bit pv;
            pv = (i % 2 == 0);
            drive(0, 0, pv, 500, 0);
            chk("bp_acc_hold", acc20, 98);
            chk("bp_valid_hold", valid20, 1);
            chk("bp_drop", drop20, pv);
        end
        pq = '{7};
        q20.push_back(model(20, Sat, pq));
        drive(1, 1, 1, 999, 1);
        chk("b2b_drop", drop20, 0);
        chk("b2b_valid", valid20, 0);
        chk("b2b_busy", busy20, 1);
        chk("b2b_acc_clr", acc20, 0);
        drive(0, 0, 1, 7, 0);
        check_result("b2b");
        to_idle("b2b");

        // Zero-length job
        pq = {};
        q20.push_back(model(20, Sat, pq));
        drive(1, 0, 0, 0, 0);
        chk("len0_valid_edge", valid20, 1);
        check_result("len0");
        to_idle("len0");

        // Maximum-length job
        pq = {};
        for (int i = 0; i < 15; i++) pq.push_back(65025);
        run_job(pq);
        check_result("len15");
        to_idle("len15");

        // Overflow: no carry at 20 bits, carry at 16 bits
        pq = '{65535, 2};
        q16.push_back(model(16, Sat, pq));
        run_job(pq);
        check_result("ovf");
        to_idle("ovf");

        // Reset in the middle of a job
        drive(1, 3, 0, 0, 0);
        drive(0, 0, 1, 9, 0);
        chk("mid_acc_before", acc20, 9);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_acc", acc20, 0);
        chk("mid_rst_valid", valid20, 0);
        chk("mid_rst_busy", busy20, 0);
        chk("mid_rst_ovf", ovf20, 0);
        drive(0, 0, 0, 0, 0);
        rst_n = 1'b1;
        pq = '{5};
        run_job(pq);
        check_result("post_rst");
        to_idle("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
Downstream consumer of the 8x8 unsigned multiplier's registered 16-bit product stream. Sums a programmed number of consecutive valid products (dot-product style) into a wider accumulator. Presents the result on a valid/ready output port. The upstream multiplier cannot be stalled, so this block never back-pressures it. Products that arrive while the block is not accumulating are discarded and flagged.

Parameters:
AccWidth, 20, accumulator/result width; must be >= 16; 16+CountWidth guarantees no overflow at max length
CountWidth, 4, width of the job length; max products per job = 2^CountWidth-1

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  reset, asynchronous, active-low
prod_i  input  16  unsigned product from multiplier
prod_valid_i  input  1  prod_i valid this cycle
start_i  input  1  begin a new job; sampled in IDLE, or in DONE when acc_ready_i is high
len_i  input  CountWidth  number of products in job; sampled with start_i
acc_o  output  AccWidth  accumulated result
acc_valid_o  output  1  acc_o valid
acc_ready_i  input  1  downstream accepts acc_o
overflow_o  output  1  carry out of AccWidth occurred during this job
drop_o  output  1  one-cycle pulse: valid product discarded
busy_o  output  1  state != IDLE

Behaviour:
- Reset (async, any state): state=IDLE; acc_o=0, acc_valid_o=0, overflow_o=0, drop_o=0, busy_o=0; remaining count=0.
- States: IDLE, ACC, DONE.
- IDLE:
  - start_i=1 and len_i!=0: clear acc and overflow, load remaining=len_i, go to ACC.
  - start_i=1 and len_i==0: clear acc and overflow, go directly to DONE. acc_o=0 is valid next cycle.
- ACC:
  - prod_valid_i=1: acc <= acc + zero-extended prod_i (mod 2^AccWidth); remaining decrements. If remaining was 1, go to DONE.
  - prod_valid_i=0: hold acc and remaining.
  - start_i is ignored.
- DONE:
  - acc_valid_o=1; acc_o and overflow_o held stable until the handshake completes.
  - acc_ready_i=1 with start_i=0: go to IDLE; acc_valid_o falls next cycle; acc_o keeps its last value.
  - acc_ready_i=1 with start_i=1: back-to-back job; reload per the IDLE rules in the same edge.
  - acc_ready_i=0: start_i is ignored.
- Timing: start at edge T; products accepted at edges T+1..T+len. With prod_valid_i continuously high, acc_valid_o is high from cycle T+len+1.
- The product arriving in the start cycle is not accumulated.
- Drop: a cycle with prod_valid_i=1 in IDLE or DONE (excluding a cycle that performs a start) gives drop_o=1 on the next cycle, otherwise 0. Registered; not sticky.
- Overflow: sticky set on carry out of the AccWidth-bit add during the job; cleared at job start.
- Mid-job reset: abandons the job; no partial result is presented.

Optional Feature:
ACC_SATURATE_EN
- Defined: on carry out, acc saturates to 2^AccWidth-1 and stays there for the rest of the job. overflow_o is still set.
- Undefined: acc wraps modulo 2^AccWidth and overflow_o is set.

Test Plan:
- Basic job: start, len=3; products 12, 30, 56 on consecutive cycles -> acc_valid_o high 4 cycles after start, acc_o=98, overflow_o=0; ready high -> IDLE, busy_o=0.
- Gaps: len=2; valid pattern 1,0,0,1 with products 65025 and 65025 -> acc_o=130050; acc_valid_o rises the cycle after the 4th product cycle.
- Back-pressure and back-to-back:
  - Result 98 with acc_ready_i=0 for 5 cycles -> acc_o stays 98; products in that window give drop_o pulses.
  - Then ready=1 with start=1, len=1, next product 7 -> acc_o=7.
- len=0 -> acc_valid_o next cycle with acc_o=0; len=15 with all products 65025 -> acc_o=975375, overflow_o=0.
- Overflow (AccWidth=16): len=2, products 65535 and 2.
  - Macro undefined -> acc_o=1, overflow_o=1.
  - ACC_SATURATE_EN defined -> acc_o=65535, overflow_o=1.
- Reset mid-ACC after 1 of 3 products -> all outputs 0 immediately; a new job with len=1 and product 5 -> acc_o=5.
